// File: rtl/fetch_pkg.sv
// Shared fetch-side types: instruction/PC widths and the tagged queue entry.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam int PC_STEP = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    typedef logic [1:0] deq_cnt_t;

endpackage

// File: rtl/instr_fetch_queue.sv
// Two-wide PC-tagging fetch queue: one word in per cycle, up to two retired per cycle.
// Handshake: a word transfers on a rising edge when in_valid && in_ready && !flush.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned     DEPTH    = 8,
    parameter logic [PC_W-1:0] PC_RESET = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [PC_W-1:0]          redirect_pc,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INSTR_W-1:0]       in_instr,
    output logic [1:0]               out_valid,
    output logic [INSTR_W-1:0]       out_instr0,
    output logic [PC_W-1:0]          out_pc0,
    output logic [INSTR_W-1:0]       out_instr1,
    output logic [PC_W-1:0]          out_pc1,
    input  deq_cnt_t                 deq_cnt,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fq_entry_t       mem_q [DEPTH];
    logic [CW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PC_W-1:0] pc_ctr_q, pc_ctr_d;

    deq_cnt_t        deq_req;
    logic [CW-1:0]   eff_deq;
    logic            enq;
    logic [AW-1:0]   rd_idx0, rd_idx1;
    fq_entry_t       slot0, slot1;

    // in_ready looks only at registered occupancy, so a full queue stays closed
    // even in a cycle where decode drains it.
    assign in_ready = (count_q < CW'(DEPTH));
    assign enq      = in_valid && in_ready && !flush;
    assign count    = count_q;

    always_comb begin
        deq_req = (deq_cnt == 2'd3) ? 2'd0 : deq_cnt;
        if (CW'(deq_req) > count_q) begin
            eff_deq = count_q;
        end else begin
            eff_deq = CW'(deq_req);
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pc_ctr_d = pc_ctr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            pc_ctr_d = redirect_pc;
        end else begin
            if (enq) begin
                wr_ptr_d = wr_ptr_q + CW'(1);
                pc_ctr_d = pc_ctr_q + PC_W'(PC_STEP);
            end
            rd_ptr_d = rd_ptr_q + eff_deq;
            count_d  = count_q + CW'(enq) - eff_deq;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pc_ctr_q <= PC_RESET;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            pc_ctr_q <= pc_ctr_d;
        end
    end

    // Data array carries no reset; validity comes solely from count_q.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[wr_ptr_q[AW-1:0]] <= '{pc: pc_ctr_q, instr: in_instr};
        end
    end

    assign rd_idx0 = rd_ptr_q[AW-1:0];
    assign rd_idx1 = rd_idx0 + AW'(1);

    always_comb begin
        slot0     = '0;
        slot1     = '0;
        out_valid = {count_q >= CW'(2), count_q >= CW'(1)};
        if (out_valid[0]) slot0 = mem_q[rd_idx0];
        if (out_valid[1]) slot1 = mem_q[rd_idx1];
    end

    assign out_instr0 = slot0.instr;
    assign out_pc0    = slot0.pc;
    assign out_instr1 = slot1.instr;
    assign out_pc1    = slot1.pc;

    a_deq_cnt_legal: assert property (@(posedge clk) disable iff (!rst_n) deq_cnt != 2'd3);
    a_count_bound:   assert property (@(posedge clk) disable iff (!rst_n) count_q <= CW'(DEPTH));
    a_no_write_full: assert property (@(posedge clk) disable iff (!rst_n) enq |-> (count_q != CW'(DEPTH)));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue against a queue-based reference model.
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 8;
    localparam logic [31:0] PC_RESET = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [1:0]  out_valid;
    logic [31:0] out_instr0, out_pc0, out_instr1, out_pc1;
    logic [1:0]  deq_cnt;
    logic [3:0]  count;

    instr_fetch_queue #(.DEPTH(DEPTH), .PC_RESET(PC_RESET)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .redirect_pc(redirect_pc),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_instr0(out_instr0), .out_pc0(out_pc0),
        .out_instr1(out_instr1), .out_pc1(out_pc1), .deq_cnt(deq_cnt), .count(count)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard: each entry is {pc, instr}, oldest at index 0
    logic [63:0] exp_q[$];
    logic [31:0] model_pc;
    int          n_checks;
    int          n_pass;
    bit          seen_wrap;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_outputs();
        logic [63:0] e0, e1;
        e0 = (exp_q.size() >= 1) ? exp_q[0] : 64'd0;
        e1 = (exp_q.size() >= 2) ? exp_q[1] : 64'd0;
        check_eq("count", 64'(count), 64'(exp_q.size()));
        check_eq("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
        check_eq("out_valid", 64'(out_valid), 64'({exp_q.size() >= 2, exp_q.size() >= 1}));
        check_eq("slot0", {out_pc0, out_instr0}, e0);
        check_eq("slot1", {out_pc1, out_instr1}, e1);
    endtask

    // driver: called just after a rising edge; checks current outputs, drives one cycle
    task automatic drive_cycle(input logic iv, input logic [31:0] ins, input logic [1:0] dq,
                               input logic fl, input logic [31:0] rpc);
        int eff;
        bit accept;
        in_valid    = iv;
        in_instr    = ins;
        deq_cnt     = dq;
        flush       = fl;
        redirect_pc = rpc;
        check_outputs();
        if (fl) begin
            exp_q.delete();
            model_pc = rpc;
        end else begin
            accept = iv && (exp_q.size() < DEPTH);
            eff = (int'(dq) < exp_q.size()) ? int'(dq) : exp_q.size();
            repeat (eff) void'(exp_q.pop_front());
            if (accept) begin
                exp_q.push_back({model_pc, ins});
                if (model_pc == 32'hFFFF_FFFC) seen_wrap = 1'b1;
                model_pc = model_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH; i++) drive_cycle(1'b0, 32'd0, 2'd2, 1'b0, 32'd0);
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        seen_wrap   = 1'b0;
        model_pc    = PC_RESET;
        rst_n       = 1'b0;
        flush       = 1'b0;
        redirect_pc = 32'd0;
        in_valid    = 1'b0;
        in_instr    = 32'd0;
        deq_cnt     = 2'd0;

        #12;
        check_outputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // three words, no dequeue
        drive_cycle(1'b1, 32'hAAAA_0001, 2'd0, 1'b0, 32'd0);
        drive_cycle(1'b1, 32'hBBBB_0002, 2'd0, 1'b0, 32'd0);
        drive_cycle(1'b1, 32'hCCCC_0003, 2'd0, 1'b0, 32'd0);
        check_eq("t1_pc1", 64'(out_pc1), 64'h4);
        idle_cycle();
        drain();

        // fill to full, offer a ninth word, then dequeue two
        for (int i = 0; i < DEPTH + 1; i++) drive_cycle(1'b1, $urandom, 2'd0, 1'b0, 32'd0);
        check_eq("t2_full_ready", 64'(in_ready), 64'd0);
        drive_cycle(1'b0, 32'd0, 2'd2, 1'b0, 32'd0);
        check_eq("t2_after_deq", 64'(count), 64'd6);
        idle_cycle();
        drain();

        // enqueue and dequeue on an empty queue
        drive_cycle(1'b1, 32'h1234_5678, 2'd2, 1'b0, 32'd0);
        check_eq("t3_count", 64'(count), 64'd1);
        idle_cycle();
        drain();

        // flush while holding five entries, with in_valid and deq_cnt active
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, $urandom, 2'd0, 1'b0, 32'd0);
        drive_cycle(1'b1, 32'hDEAD_BEEF, 2'd1, 1'b1, 32'h0000_0100);
        drive_cycle(1'b1, 32'h0BAD_F00D, 2'd0, 1'b0, 32'd0);
        check_eq("t4_redirect_pc", 64'(out_pc0), 64'h100);
        idle_cycle();

        // random stream near the top of the address space to cover PC wrap
        drive_cycle(1'b0, 32'd0, 2'd0, 1'b1, 32'hFFFF_FF00);
        for (int i = 0; i < 1000; i++) begin
            logic fl;
            fl = ($urandom_range(0, 199) == 0);
            drive_cycle($urandom_range(0, 3) != 0, $urandom, 2'($urandom_range(0, 2)), fl,
                        ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFE0 : ($urandom & 32'hFFFF_FFFC));
        end
        check_eq("t5_wrap_seen", 64'(seen_wrap), 64'd1);
        drain();

        // asynchronous reset with four entries held
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, $urandom, 2'd0, 1'b0, 32'd0);
        check_eq("t6_pre_count", 64'(count), 64'd4);
        in_valid = 1'b0;
        deq_cnt  = 2'd0;
        rst_n    = 1'b0;
        #1;
        exp_q.delete();
        model_pc = PC_RESET;
        check_outputs();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive_cycle(1'b1, 32'h5555_AAAA, 2'd0, 1'b0, 32'd0);
        check_eq("t6_pc_after_reset", 64'(out_pc0), 64'(PC_RESET));
        idle_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
